// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised pipeline boundary register with a valid/ready handshake and a
// two-entry skid buffer (main + skid).  It replaces fixed-field stage
// registers such as MEM/WB.  The main entry drives the outputs.  The control
// vector is forced to zero whenever the slot is invalid, so that an empty or
// flushed slot can never raise RegWrite or similar strobes downstream.
//
// Optional feature macro: PIPE_STAGE_REG_PERF_EN
//   When defined, the stall_cnt and flush_cnt saturating performance counter
//   ports are added.
//
// Ports:
//   clk        in   1       clock, all state updates on posedge
//   rst        in   1       synchronous active-high reset
//   flush      in   1       kill all held entries this cycle
//   in_valid   in   1       upstream slot valid
//   in_ready   out  1       stage can accept this cycle (no path from out_ready)
//   in_ctrl    in   CTRL_W  upstream control vector
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       downstream slot valid
//   out_ready  in   1       downstream accepts this cycle
//   out_ctrl   out  CTRL_W  control vector, all zeros whenever out_valid=0
//   out_data   out  DATA_W  payload of main entry, holds last value when invalid
//   stall_cnt  out  CNT_W   (perf only) cycles with out_valid & ~out_ready
//   flush_cnt  out  CNT_W   (perf only) flush cycles that killed live entries
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 85,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_REG_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CTRL_W-1:0]  r_main_ctrl;
    logic [DATA_W-1:0]  r_main_data;
    logic [CTRL_W-1:0]  r_skid_ctrl;
    logic [DATA_W-1:0]  r_skid_data;

    logic w_out_valid;
    logic w_accept;
    logic w_take;
    logic w_ld_main_in;
    logic w_ld_main_skid;
    logic w_ld_skid;

    // in_ready depends only on reset and local state, never on out_ready.
    assign in_ready    = ~rst & (r_state != S_FULL);
    assign w_out_valid = (r_state != S_EMPTY);
    assign out_valid   = w_out_valid;
    assign out_data    = r_main_data;
    assign w_accept    = in_valid & in_ready;
    assign w_take      = w_out_valid & out_ready;

    // Bubble masking: the stored control vector may be stale after a take or
    // flush, so each bit is gated by valid on the way out.
    genvar gi;
    generate
        for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
            assign out_ctrl[gi] = r_main_ctrl[gi] & w_out_valid;
        end
    endgenerate

    always_comb begin
        w_state_next   = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush) begin
            // Anything accepted this cycle is dropped along with held entries.
            w_state_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state_next = S_ONE;
                        w_ld_main_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_take && w_accept) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_take) begin
                        w_state_next = S_EMPTY;
                    end else if (w_accept) begin
                        w_state_next = S_FULL;
                        w_ld_skid    = 1'b1;
                    end
                end
                S_FULL: begin
                    if (w_take) begin
                        w_state_next   = S_ONE;
                        w_ld_main_skid = 1'b1;
                    end
                end
                default: w_state_next = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_ld_main_in) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_ld_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_ld_skid) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_REG_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Both counters stick at all-ones; flush does not clear them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_out_valid && !out_ready && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (flush && (r_state != S_EMPTY) && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    // Counter width only matters when the perf counters are built.
    generate
        if (CNT_W > 0) begin : g_no_perf
        end
    endgenerate
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline boundary register that replaces the fixed-field, negedge-sampled stage registers between pipeline stages (e.g. MEM/WB).
- Carries one control vector and one data vector per stage slot, using a valid/ready handshake with a two-entry skid buffer so backpressure never drops an instruction.
- Supports flush, and forces the control vector to zero on bubbles so that a killed or empty slot can never assert RegWrite or similar strobes downstream.
- Single posedge clock domain; instantiated once per stage boundary.

Parameters:
- CTRL_W, 4, width of control vector (RegSrc, RegWrite, load, ...); zeroed when slot invalid
- DATA_W, 85, width of payload vector (ALU result, mem data, dest reg, immediate, concatenated by the instantiator)
- CNT_W, 32, width of performance counters (used only with optional feature)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- flush  in  1  kill all held entries this cycle
- in_valid  in  1  upstream slot valid
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  upstream control vector
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  downstream slot valid
- out_ready  in  1  downstream accepts this cycle
- out_ctrl  out  CTRL_W  control vector; all zeros whenever out_valid=0
- out_data  out  DATA_W  payload of main entry; holds last value when invalid

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each with ctrl+data. State is one of EMPTY, ONE, FULL.
- Handshakes: accept = in_valid & in_ready; take = out_valid & out_ready.
- Ready and valid: in_ready = ~rst & (state != FULL), with no combinational path from out_ready. out_valid = (state != EMPTY).
- EMPTY:
  - accept -> ONE, main <= in.
  - otherwise stay.
- ONE:
  - take & accept -> ONE, main <= in.
  - take only -> EMPTY.
  - accept only -> FULL, skid <= in.
  - neither -> hold.
- FULL:
  - take -> ONE, main <= skid.
  - otherwise hold; in_ready = 0.
- Latency: 1 cycle from accept to out_valid when empty. Throughput is 1 per cycle while out_ready = 1.
- Flush:
  - Next state is EMPTY regardless of take or accept.
  - Data accepted in the flush cycle is discarded.
  - out_data keeps its old value, while out_ctrl goes to zero the next cycle.
- Priority: rst > flush > normal transitions.
- Reset: state EMPTY, out_valid 0, out_ctrl 0, out_data 0, skid contents 0, in_ready 0 during reset.
- Contract: in_valid = 1 while in_ready = 0 is legal; the upstream holds its data.
- Bubble invariant: out_valid = 0 implies out_ctrl = 0 on every cycle, including the first cycle after reset.
- Ordering: entries leave in arrival order; no reordering or duplication.

Optional Feature:
- Macro: PIPE_STAGE_REG_PERF_EN.
- When defined, the block adds output ports stall_cnt [CNT_W] and flush_cnt [CNT_W]:
  - stall_cnt increments on each cycle with out_valid & ~out_ready.
  - flush_cnt increments on each cycle where flush is asserted and state != EMPTY.
  - Both counters saturate at all-ones, are reset to 0 by rst, and are not cleared by flush.
- When undefined, these ports and their logic do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then stream: rst 2 cycles; in_valid=1 with data 1,2,3 on consecutive cycles, out_ready=1 -> out_valid rises 1 cycle after first accept; out_data 1,2,3 on consecutive cycles; out_ctrl=in_ctrl; in_ready stays 1.
- Backpressure: out_ready=0, push A=0x11 then B=0x22 -> state FULL, in_ready=0, C=0x33 held upstream. Raise out_ready -> outputs A, B, C in order with no loss or duplication.
- Flush while FULL: hold A, B; assert flush 1 cycle with in_valid=1, data D -> next cycle out_valid=0, out_ctrl=0, in_ready=1; D never appears.
- Bubble ctrl: in_ctrl=4'b1111 pushed then taken, in_valid=0 -> out_valid=0 and out_ctrl=4'b0000 on the following cycle, out_data unchanged.
- Reset mid-operation: FULL state, rst asserted for 1 cycle -> out_valid=0, out_ctrl=0, out_data=0, in_ready=0 during reset, 1 after.
- Perf (PIPE_STAGE_REG_PERF_EN): out_valid=1, out_ready=0 for 5 cycles, then 1 flush -> stall_cnt=5, flush_cnt=1. With CNT_W=3 and 9 stall cycles -> stall_cnt saturates at 7.
